unigate_cfg_bank: RTL and testbench

Configuration bank for an array of universal 3-input gate cells. A host writes each cell's 8-bit function code together with its per-pin wiring selectors into a shadow store. A commit sequence then copies the shadow store cell by cell into the active store that drives the gate array. Double-buffering lets a new configuration be staged while the array keeps running the old one. A registered readback port returns one pin selector of one cell, as the single-cell wiring lookup does today.

---
 rtl/unigate_cfg_bank.sv | 150 +++++++++++++++
 tb/tb_unigate_cfg_bank.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unigate_cfg_bank.sv
// Double-buffered configuration bank for an array of universal 3-input gate cells.
// The host stages entries in a shadow store; a commit copies them cell by cell into the active store.
module unigate_cfg_bank #(
  parameter  int NCELL  = 8,
  parameter  int NPIN   = 6,
  parameter  int SEL_W  = 3,
  parameter  int MAXSEL = 4,
  localparam int CW     = $clog2(NCELL),
  localparam int PW     = $clog2(NPIN)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [CW-1:0]               cfg_cell,
  input  logic [7:0]                  cfg_func,
  input  logic [NPIN*SEL_W-1:0]       cfg_wiring,
  input  logic                        commit,
  input  logic                        clear,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic                        dirty,
  input  logic [CW-1:0]               rd_cell,
  input  logic [PW-1:0]               rd_pin,
  output logic [SEL_W-1:0]            rd_wiring,
  output logic [7:0]                  rd_func,
  output logic [NCELL*NPIN*SEL_W-1:0] gate_wiring
);

  localparam logic [CW-1:0] LAST = CW'(NCELL - 1);

  typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_CLEAR} state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [CW-1:0]                  r_k;
  logic                           w_last;
  logic                           w_xfer;
  logic                           w_sel_ok;
  logic                           w_cell_ok;
  logic                           w_rd_ok;

  logic [7:0]                     r_sh_func  [NCELL];
  logic [NPIN-1:0][SEL_W-1:0]     r_sh_wir   [NCELL];
  logic [7:0]                     r_act_func [NCELL];
  logic [NPIN-1:0][SEL_W-1:0]     r_act_wir  [NCELL];
  logic [NCELL-1:0]               r_act_nz;
  logic                           r_err;
  logic                           r_dirty;
  logic [SEL_W-1:0]               r_rd_wiring;
  logic [7:0]                     r_rd_func;

  assign w_last    = (r_k == LAST);
  assign w_xfer    = cfg_valid && (r_state == S_IDLE);
  assign w_cell_ok = (int'(cfg_cell) < NCELL);
  assign w_rd_ok   = (int'(rd_cell) < NCELL) && (int'(rd_pin) < NPIN);

  always_comb begin
    w_sel_ok = 1'b1;
    for (int p = 0; p < NPIN; p++) begin
      if (cfg_wiring[SEL_W*p +: SEL_W] > SEL_W'(MAXSEL)) w_sel_ok = 1'b0;
    end
  end

  // FSM state register and cell walk counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= (r_state != S_IDLE && !w_last) ? r_k + 1'b1 : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (clear)       w_state_nxt = S_CLEAR;
        else if (commit) w_state_nxt = S_COMMIT;
      end
      S_COMMIT, S_CLEAR: begin
        if (w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign cfg_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = busy && w_last;

  // Stores, status flags and registered readback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCELL; c++) begin
        r_sh_func[c]  <= '0;
        r_sh_wir[c]   <= '0;
        r_act_func[c] <= '0;
        r_act_wir[c]  <= '0;
      end
      r_act_nz    <= '0;
      r_err       <= 1'b0;
      r_dirty     <= 1'b0;
      r_rd_wiring <= '0;
      r_rd_func   <= '0;
    end else begin
      if (w_xfer) begin
        if (w_sel_ok && w_cell_ok) begin
          r_sh_func[cfg_cell] <= cfg_func;
          r_sh_wir[cfg_cell]  <= cfg_wiring;
          r_dirty             <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end
      case (r_state)
        S_COMMIT: begin
          r_act_func[r_k] <= r_sh_func[r_k];
          r_act_wir[r_k]  <= r_sh_wir[r_k];
          r_act_nz[r_k]   <= (r_sh_func[r_k] != '0) || (r_sh_wir[r_k] != '0);
          if (w_last) r_dirty <= 1'b0;
        end
        S_CLEAR: begin
          r_sh_func[r_k] <= '0;
          r_sh_wir[r_k]  <= '0;
          if (w_last) begin
            r_err   <= 1'b0;
            r_dirty <= |r_act_nz;
          end
        end
        default: ;
      endcase
      r_rd_wiring <= w_rd_ok ? r_act_wir[rd_cell][rd_pin] : '0;
      r_rd_func   <= (int'(rd_cell) < NCELL) && (int'(rd_pin) < NPIN) ? r_act_func[rd_cell] : '0;
    end
  end

  assign err       = r_err;
  assign dirty     = r_dirty;
  assign rd_wiring = r_rd_wiring;
  assign rd_func   = r_rd_func;

  for (genvar c = 0; c < NCELL; c++) begin : g_gate
    assign gate_wiring[c*NPIN*SEL_W +: NPIN*SEL_W] = r_act_wir[c];
  end

endmodule

// File: tb/tb_unigate_cfg_bank.sv
// Directed bench for unigate_cfg_bank: staged writes, commit/clear sequencing, readback and reset abort.
module tb_unigate_cfg_bank;

  localparam int NCELL = 8;
  localparam int NPIN  = 6;
  localparam int SEL_W = 3;
  localparam int CW    = 3;
  localparam int PW    = 3;
  localparam int WW    = NPIN * SEL_W;

  localparam logic [WW-1:0] W3  = 18'b100_010_011_010_001_001;
  localparam logic [WW-1:0] W5  = 18'b000_001_010_011_100_000;
  localparam logic [WW-1:0] W1  = 18'b001_001_001_001_001_001;
  localparam logic [WW-1:0] WBAD = 18'b000_000_000_000_000_101;

  logic                  clk;
  logic                  rst_n;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [CW-1:0]         cfg_cell;
  logic [7:0]            cfg_func;
  logic [WW-1:0]         cfg_wiring;
  logic                  commit;
  logic                  clear;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  dirty;
  logic [CW-1:0]         rd_cell;
  logic [PW-1:0]         rd_pin;
  logic [SEL_W-1:0]      rd_wiring;
  logic [7:0]            rd_func;
  logic [NCELL*WW-1:0]   gate_wiring;

  int n_chk  = 0;
  int n_fail = 0;

  unigate_cfg_bank #(.NCELL(NCELL), .NPIN(NPIN), .SEL_W(SEL_W), .MAXSEL(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_cell(cfg_cell),
    .cfg_func(cfg_func), .cfg_wiring(cfg_wiring),
    .commit(commit), .clear(clear), .busy(busy), .done(done),
    .err(err), .dirty(dirty),
    .rd_cell(rd_cell), .rd_pin(rd_pin), .rd_wiring(rd_wiring), .rd_func(rd_func),
    .gate_wiring(gate_wiring)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] gcell(input int c);
    return gate_wiring[c*WW +: WW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [CW-1:0] c, input logic [7:0] f, input logic [WW-1:0] w);
    cfg_valid = 1'b1; cfg_cell = c; cfg_func = f; cfg_wiring = w;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic run_seq(input bit do_clear);
    if (do_clear) clear = 1'b1; else commit = 1'b1;
    step();
    clear = 1'b0; commit = 1'b0;
    repeat (NCELL) step();
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_cell = '0; cfg_func = '0; cfg_wiring = '0;
    commit = 1'b0; clear = 1'b0; rd_cell = '0; rd_pin = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_ready", cfg_ready, 1);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dirty", dirty, 0);
    chk("rst_gate", |gate_wiring, 0);
    for (int c = 0; c < NCELL; c++) begin
      for (int p = 0; p < NPIN; p++) begin
        rd_cell = CW'(c); rd_pin = PW'(p);
        step();
        chk($sformatf("rst_rdw_c%0d_p%0d", c, p), rd_wiring, 0);
        chk($sformatf("rst_rdf_c%0d_p%0d", c, p), rd_func, 0);
      end
    end

    // Stage cell 3 and commit it
    write_cfg(3, 8'h01, W3);
    chk("wr3_dirty", dirty, 1);
    chk("wr3_err", err, 0);
    chk("wr3_gate_before", gcell(3), 0);
    commit = 1'b1;
    step();
    commit = 1'b0;
    chk("cm_busy0", busy, 1);
    chk("cm_ready0", cfg_ready, 0);
    chk("cm_done0", done, 0);
    for (int i = 1; i < NCELL; i++) begin
      step();
      chk($sformatf("cm_done_e%0d", i), done, (i == NCELL-1));
      chk($sformatf("cm_busy_e%0d", i), busy, 1);
      chk($sformatf("cm_gate3_e%0d", i), gcell(3), (i >= 4) ? W3 : 0);
    end
    step();
    chk("cm_end_busy", busy, 0);
    chk("cm_end_done", done, 0);
    chk("cm_end_dirty", dirty, 0);
    chk("cm_end_ready", cfg_ready, 1);
    for (int c = 0; c < NCELL; c++)
      chk($sformatf("cm_gate_c%0d", c), gcell(c), (c == 3) ? W3 : 0);
    rd_cell = 3; rd_pin = 5;
    step();
    chk("rd3_p5", rd_wiring, 3'b100);
    chk("rd3_func", rd_func, 8'h01);
    rd_pin = 0;
    #2;
    chk("rd_latency_hold", rd_wiring, 3'b100);
    step();
    chk("rd3_p0", rd_wiring, 3'b001);
    rd_pin = 6;
    step();
    chk("rd_pin_oor", rd_wiring, 0);
    rd_cell = 2; rd_pin = 0;
    step();
    chk("rd2_func", rd_func, 0);

    // Rejected write, then commit and clear
    write_cfg(2, 8'hAA, WBAD);
    chk("bad_err", err, 1);
    chk("bad_dirty", dirty, 0);
    run_seq(1'b0);
    chk("bad_gate2", gcell(2), 0);
    chk("bad_gate3", gcell(3), W3);
    chk("bad_err_after_commit", err, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 1; i < NCELL; i++) begin
      step();
      chk($sformatf("cl_done_e%0d", i), done, (i == NCELL-1));
      chk($sformatf("cl_err_e%0d", i), err, 1);
    end
    step();
    chk("cl_end_err", err, 0);
    chk("cl_end_busy", busy, 0);
    chk("cl_end_dirty", dirty, 1);
    run_seq(1'b0);
    chk("cl_commit_gate3", gcell(3), 0);
    chk("cl_commit_dirty", dirty, 0);

    // Write held during a commit, commit re-asserted mid-sequence
    write_cfg(5, 8'h5C, W5);
    commit = 1'b1;
    step();
    commit = 1'b0;
    step(); step();
    cfg_valid = 1'b1; cfg_cell = 1; cfg_func = 8'h11; cfg_wiring = W1;
    #1;
    chk("hold_ready", cfg_ready, 0);
    step();
    commit = 1'b1;
    step();
    commit = 1'b0;
    repeat (3) step();
    chk("hold_done", done, 1);
    step();
    chk("hold_ready_idle", cfg_ready, 1);
    chk("hold_gate5", gcell(5), W5);
    chk("hold_gate1", gcell(1), 0);
    step();
    cfg_valid = 1'b0;
    chk("hold_no_recommit", busy, 0);
    chk("hold_dirty", dirty, 1);
    chk("hold_err", err, 0);
    run_seq(1'b0);
    chk("hold_commit_gate1", gcell(1), W1);
    chk("hold_commit_gate5", gcell(5), W5);

    // Clear wins over commit; same-cycle write is zeroed
    cfg_valid = 1'b1; cfg_cell = 6; cfg_func = 8'h66; cfg_wiring = W1;
    clear = 1'b1; commit = 1'b1;
    step();
    cfg_valid = 1'b0; clear = 1'b0; commit = 1'b0;
    chk("prio_busy", busy, 1);
    repeat (NCELL) step();
    chk("prio_gate6", gcell(6), 0);
    chk("prio_dirty", dirty, 1);
    run_seq(1'b0);
    chk("prio_commit_gate6", gcell(6), 0);
    chk("prio_commit_gate1", gcell(1), 0);
    chk("prio_commit_dirty", dirty, 0);

    // Same-cycle write to cell 0 plus commit
    cfg_valid = 1'b1; cfg_cell = 0; cfg_func = 8'hA5; cfg_wiring = W3;
    commit = 1'b1;
    step();
    cfg_valid = 1'b0; commit = 1'b0;
    step();
    chk("same_gate0_e1", gcell(0), W3);
    repeat (NCELL-1) step();
    chk("same_busy_end", busy, 0);
    rd_cell = 0; rd_pin = 5;
    step();
    chk("same_rd_func", rd_func, 8'hA5);
    chk("same_rd_wiring", rd_wiring, 3'b100);

    // Reset aborts a commit in progress
    write_cfg(7, 8'h77, W5);
    commit = 1'b1;
    step();
    commit = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ready", cfg_ready, 1);
    chk("abort_gate", |gate_wiring, 0);
    chk("abort_dirty", dirty, 0);
    chk("abort_err", err, 0);
    step();
    rst_n = 1'b1;
    run_seq(1'b0);
    chk("abort_recommit_gate", |gate_wiring, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
